// File: rtl/gpp_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpp_arb_pkg
// Description : Shared types and helpers for the X register write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package gpp_arb_pkg;

    localparam int X_DATA_W = 16;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Index width for an n-entry requester vector, never narrower than 1 bit
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/x_write_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin find-first starting at i_ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import gpp_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    logic [IDX_W-1:0] w_c;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_c     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_c = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
            if (!o_any && i_req[w_c]) begin
                o_any      = 1'b1;
                o_grant[w_c] = 1'b1;
                o_idx      = w_c;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/x_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : x_write_arbiter
// Description : Round-robin arbiter for the X register write port with
//               optional locked bursts. Optional macro XARB_WRITE_COUNT_EN
//               adds a saturating transfer counter output wr_count.
// Revision    : 1.0 - initial release
// ============================================================================
module x_write_arbiter
    import gpp_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = X_DATA_W,
    parameter int MAX_HOLD = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_lock,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         x_in,
    output logic                      x_w,
    output logic [idx_w(NUM_REQ)-1:0] grant_id,
`ifdef XARB_WRITE_COUNT_EN
    output logic [15:0]               wr_count,
`endif
    output logic                      locked
);

    localparam int               c_IDX_W    = idx_w(NUM_REQ);
    localparam logic [c_IDX_W-1:0] c_LAST   = c_IDX_W'(NUM_REQ - 1);
    localparam logic [3:0]       c_HOLD_LIM = 4'(MAX_HOLD - 1);
    localparam logic             c_LOCK_OK  = (MAX_HOLD > 1);

    arb_state_t         r_state, w_next_state;
    logic [c_IDX_W-1:0] r_rr_ptr, w_next_ptr;
    logic [3:0]         r_hold_cnt, w_next_hold;
    logic [DATA_W-1:0]  r_x_in;
    logic               r_x_w;
    logic [c_IDX_W-1:0] r_grant_id;

    logic [NUM_REQ-1:0] w_pick_grant;
    logic [c_IDX_W-1:0] w_pick_idx;
    logic               w_pick_any;
    logic [NUM_REQ-1:0] w_ready;
    logic               w_xfer;
    logic [c_IDX_W-1:0] w_win_idx;
    logic [c_IDX_W-1:0] w_holder_next;
    logic [DATA_W-1:0]  w_data [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign w_data[i] = req_data[i*DATA_W +: DATA_W];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    assign w_holder_next = (r_grant_id == c_LAST) ? '0 : r_grant_id + c_IDX_W'(1);

    always_comb begin
        w_next_state = r_state;
        w_next_ptr   = r_rr_ptr;
        w_next_hold  = r_hold_cnt;
        w_ready      = '0;
        w_xfer       = 1'b0;
        w_win_idx    = r_grant_id;
        // Nothing is accepted while reset is asserted
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    if (w_pick_any) begin
                        w_ready   = w_pick_grant;
                        w_xfer    = 1'b1;
                        w_win_idx = w_pick_idx;
                        if (req_lock[w_pick_idx] && c_LOCK_OK) begin
                            w_next_state = LOCKED;
                            w_next_hold  = 4'd1;
                        end else begin
                            w_next_ptr = (w_pick_idx == c_LAST) ? '0 : w_pick_idx + c_IDX_W'(1);
                        end
                    end
                end
                LOCKED: begin
                    if (req_valid[r_grant_id]) begin
                        w_ready[r_grant_id] = 1'b1;
                        w_xfer              = 1'b1;
                    end
                    if (req_valid[r_grant_id] && req_lock[r_grant_id] && (r_hold_cnt < c_HOLD_LIM)) begin
                        w_next_hold = r_hold_cnt + 4'd1;
                    end else begin
                        w_next_state = IDLE;
                        w_next_hold  = 4'd0;
                        w_next_ptr   = w_holder_next;
                    end
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_hold_cnt <= 4'd0;
            r_x_in     <= '0;
            r_x_w      <= 1'b0;
            r_grant_id <= '0;
        end else begin
            r_state    <= w_next_state;
            r_rr_ptr   <= w_next_ptr;
            r_hold_cnt <= w_next_hold;
            r_x_w      <= w_xfer;
            if (w_xfer) begin
                r_x_in     <= w_data[w_win_idx];
                r_grant_id <= w_win_idx;
            end
        end
    end

`ifdef XARB_WRITE_COUNT_EN
    logic [15:0] r_wr_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_count <= 16'd0;
        end else if (w_xfer && (r_wr_count != 16'hFFFF)) begin
            r_wr_count <= r_wr_count + 16'd1;
        end
    end

    assign wr_count = r_wr_count;
`endif

    assign req_ready = w_ready;
    assign x_in      = r_x_in;
    assign x_w       = r_x_w;
    assign grant_id  = r_grant_id;
    assign locked    = (r_state == LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_x_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_x_write_arbiter
// Description : Self-checking bench: per-cycle reference model plus directed
//               scenarios with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_x_write_arbiter;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int MH = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NR-1:0]  req_valid = '1;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR-1:0]  req_lock = '0;
    logic [NR-1:0]  req_ready;
    logic [DW-1:0]  x_in;
    logic           x_w;
    logic [1:0]     grant_id;
    logic           locked;
`ifdef XARB_WRITE_COUNT_EN
    logic [15:0]    wr_count;
`endif

    int checks = 0;
    int errors = 0;

    x_write_arbiter #(
        .NUM_REQ  (NR),
        .DATA_W   (DW),
        .MAX_HOLD (MH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_lock  (req_lock),
        .req_ready (req_ready),
        .x_in      (x_in),
        .x_w       (x_w),
        .grant_id  (grant_id),
`ifdef XARB_WRITE_COUNT_EN
        .wr_count  (wr_count),
`endif
        .locked    (locked)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [DW-1:0] d);
        req_data[i*DW +: DW] = d;
    endtask

    // Reference model: who may write, and what the register port shows next
    bit            m_lock;
    bit            m_xw;
    int            m_ptr, m_gid, m_beats, m_cnt, win;
    logic [DW-1:0] m_xin;
    logic [NR-1:0] e_ready;

    task automatic m_reset();
        m_lock = 0; m_xw = 0; m_ptr = 0; m_gid = 0; m_beats = 0; m_cnt = 0; m_xin = '0;
    endtask

    initial begin : model
        @(posedge clk);
        m_reset();
        forever begin
            @(negedge clk);
            win = -1;
            if (!rst) begin
                if (m_lock) begin
                    if (req_valid[m_gid]) win = m_gid;
                end else begin
                    for (int k = 0; k < NR; k++)
                        if (win < 0 && req_valid[(m_ptr + k) % NR]) win = (m_ptr + k) % NR;
                end
            end
            e_ready = '0;
            if (win >= 0) e_ready[win] = 1'b1;
            chk("m_ready", req_ready, e_ready);
            chk("m_x_w", x_w, m_xw);
            chk("m_x_in", x_in, m_xin);
            chk("m_grant_id", grant_id, m_gid);
            chk("m_locked", locked, m_lock);
`ifdef XARB_WRITE_COUNT_EN
            chk("m_wr_count", wr_count, m_cnt);
`endif
            @(posedge clk);
            if (rst) begin
                m_reset();
            end else begin
                m_xw = (win >= 0);
                if (win >= 0) begin
                    m_xin = req_data[win*DW +: DW];
                    m_gid = win;
                    if (m_cnt < 16'hFFFF) m_cnt++;
                end
                if (!m_lock) begin
                    if (win >= 0) begin
                        if (req_lock[win] && MH > 1) begin
                            m_lock  = 1;
                            m_beats = 1;
                        end else begin
                            m_ptr = (win + 1) % NR;
                        end
                    end
                end else if (win >= 0 && req_lock[win] && m_beats + 1 < MH) begin
                    m_beats++;
                end else begin
                    m_lock = 0;
                    m_ptr  = (m_gid + 1) % NR;
                end
            end
        end
    end

    logic [DW-1:0] fair_seq [5] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0001};

    initial begin : stim
        // Reset held two cycles with everyone requesting
        for (int i = 0; i < NR; i++) set_data(i, DW'(16'h1000 + i));
        step(); step();
        chk("rst_ready", req_ready, 4'b0000);
        chk("rst_x_w", x_w, 1'b0);
        chk("rst_x_in", x_in, 16'h0000);
        chk("rst_locked", locked, 1'b0);
        rst = 0; req_valid = '0;
        step();

        // Single write
        set_data(0, 16'h6AB3); req_valid = 4'b0001;
        #1 chk("single_ready", req_ready, 4'b0001);
        step();
        chk("single_x_w", x_w, 1'b1);
        chk("single_x_in", x_in, 16'h6AB3);
        req_valid = '0;
        step();
        chk("single_x_w_off", x_w, 1'b0);

        // Fairness from a fresh pointer
        rst = 1; step(); rst = 0;
        for (int i = 0; i < NR; i++) set_data(i, DW'(i + 1));
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("fair_x_w", x_w, 1'b1);
            chk("fair_x_in", x_in, fair_seq[k]);
        end
        // Move the pointer to requester 2
        req_valid = 4'b0010; set_data(1, 16'h1111);
        step();

        // Locked burst by requester 2 against 0 and 1
        req_valid = 4'b0111; req_lock = 4'b0100; set_data(2, 16'hFFFF);
        #1 chk("burst_ready", req_ready, 4'b0100);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("burst_x_w", x_w, 1'b1);
            chk("burst_x_in", x_in, 16'hFFFF);
            chk("burst_locked", locked, k < 4);
        end
        chk("burst_wrap_ready", req_ready, 4'b0001);
        step();
        chk("burst_next_grant", grant_id, 2'd0);
        req_valid = '0; req_lock = '0;
        step();

        // Early release by requester 1 after two beats
        req_valid = 4'b1010; req_lock = 4'b0010;
        set_data(1, 16'hAAAA); set_data(3, 16'h3333);
        step(); step();
        chk("early_locked", locked, 1'b1);
        req_valid = 4'b1000;
        #1 chk("early_stall", req_ready, 4'b0000);
        step();
        chk("early_unlocked", locked, 1'b0);
        chk("early_gap", x_w, 1'b0);
        chk("early_ready3", req_ready, 4'b1000);
        step();
        chk("early_x_in", x_in, 16'h3333);
        chk("early_grant", grant_id, 2'd3);
        req_valid = '0; req_lock = '0;
        step();

        // Reset in the middle of a burst
        req_valid = 4'b0001; req_lock = 4'b0001; set_data(0, 16'h5A5A);
        step();
        rst = 1;
        step();
        chk("midrst_x_w", x_w, 1'b0);
        chk("midrst_locked", locked, 1'b0);
        rst = 0; req_valid = 4'b1001; req_lock = '0;
        #1 chk("midrst_ready", req_ready, 4'b0001);
        step();
        chk("midrst_x_in", x_in, 16'h5A5A);
        chk("midrst_grant", grant_id, 2'd0);

        // Mixed traffic, checked by the model only
        for (int k = 0; k < 80; k++) begin
            req_valid = NR'($urandom);
            req_lock  = NR'($urandom);
            for (int i = 0; i < NR; i++) set_data(i, DW'($urandom));
            step();
        end
        req_valid = '0; req_lock = '0;
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
